// File: rtl/dcache_nway_pkg.sv
// Shared types and address helpers for the N-way write-back data cache.
// The hit/miss counters are built only when DCACHE_HITCNT_EN is defined.
package dcache_nway_pkg;

   typedef enum logic [1:0] {RamFree, RamBusy, RamAccess, RamError} ramstate_t;

   typedef enum logic [2:0] {
      StCompare,
      StWb,
      StFill,
      StFlushScan,
      StFlushWb,
      StDone
   } dcstate_t;

   // Extracts a field of the given width from the given bit position of the address.
   function automatic logic [31:0] addr_field(input logic [31:0] addr, input int unsigned lsb,
                                              input int unsigned width);
      return (addr >> lsb) & ((32'd1 << width) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_join(input logic [31:0] tag, input logic [31:0] idx,
                                             input logic [31:0] boff, input int unsigned boff_w,
                                             input int unsigned idx_w);
      return (tag << (2 + boff_w + idx_w)) | (idx << (2 + boff_w)) | (boff << 2);
   endfunction

endpackage

// File: rtl/dcache_nway_if.sv
// The datapath dmem port and the word-wide RAM port, as seen by the cache.
interface dcache_nway_if;
   import dcache_nway_pkg::*;

   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic [31:0] dmemload;
   logic        dhit;
   logic        halt;
   logic        flushed;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   ramstate_t   ramstate;

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, ramstate,
      output dmemload, dhit, flushed, dREN, dWEN, daddr, dstore
   );

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, ramstate,
      input  dmemload, dhit, flushed, dREN, dWEN, daddr, dstore
   );
endinterface

// File: rtl/dcache_nway_plru.sv
// Per-set tree pseudo-LRU: each node bit points toward the less recently used half.
module dcache_plru #(
   parameter int unsigned WAYS = 2,
   parameter int unsigned SETS = 8,
   localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
   localparam int unsigned IDX_W = $clog2(SETS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic             upd_i,
   input  logic [WAY_W-1:0] access_way_i,
   output logic [WAY_W-1:0] victim_o
);

   if (WAYS == 1) begin : g_single
      assign victim_o = '0;
   end else begin : g_tree
      logic [WAYS-2:0] tree_q [SETS];
      logic [WAYS-2:0] tree_d;

      // Node n (heap order, root 1) lives at bit n-1.
      always_comb begin
         logic [WAY_W-1:0] node;
         tree_d   = tree_q[idx_i];
         victim_o = '0;
         node     = WAY_W'(1);
         for (int l = 0; l < int'(WAY_W); l++) begin
            victim_o[WAY_W-1-l] = tree_q[idx_i][node - WAY_W'(1)];
            node = (node << 1) | WAY_W'(tree_q[idx_i][node - WAY_W'(1)]);
         end
         node = WAY_W'(1);
         for (int l = 0; l < int'(WAY_W); l++) begin
            tree_d[node - WAY_W'(1)] = ~access_way_i[WAY_W-1-l];
            node = (node << 1) | WAY_W'(access_way_i[WAY_W-1-l]);
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            for (int s = 0; s < int'(SETS); s++) tree_q[s] <= '0;
         end else if (upd_i) begin
            tree_q[idx_i] <= tree_d;
         end
      end
   end

endmodule

// File: rtl/dcache_nway.sv
// N-way set-associative write-back data cache with PLRU replacement and halt flush.
// Optional DCACHE_HITCNT_EN adds saturating hit_count/miss_count ports.
module dcache_nway
   import dcache_nway_pkg::*;
#(
   parameter int unsigned WAYS      = 2,
   parameter int unsigned SETS      = 8,
   parameter int unsigned BLK_WORDS = 2
) (
   input logic CLK,
   input logic RST,
   dcache_nway_if.slave bus
`ifdef DCACHE_HITCNT_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int unsigned IDX_W  = $clog2(SETS);
   localparam int unsigned BOFF_W = $clog2(BLK_WORDS);
   localparam int unsigned CNT_W  = (BLK_WORDS > 1) ? BOFF_W : 1;
   localparam int unsigned TAG_W  = 30 - BOFF_W - IDX_W;
   localparam int unsigned SCAN_W = $clog2(WAYS) + IDX_W;

   typedef struct packed {
      logic             valid;
      logic             dirty;
      logic [TAG_W-1:0] tag;
   } frame_meta_t;

   frame_meta_t meta_q [SETS][WAYS];
   logic [31:0] data_q [SETS][WAYS][BLK_WORDS];

   dcstate_t          state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SCAN_W-1:0] scan_q, scan_d;
   logic [WAY_W-1:0]  victim_q, victim_d;

   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_idx;
   logic [CNT_W-1:0] req_boff;
   logic             req, hit, inv_found, cnt_last, scan_last;
   logic [WAY_W-1:0] hit_way, inv_way, plru_victim, victim;
   logic [WAY_W-1:0] scan_way;
   logic [IDX_W-1:0] scan_set;
   logic             plru_upd, wr_hit, fill_we, fill_done, wb_clean;

   assign req_tag  = TAG_W'(addr_field(bus.dmemaddr, 2 + BOFF_W + IDX_W, TAG_W));
   assign req_idx  = IDX_W'(addr_field(bus.dmemaddr, 2 + BOFF_W, IDX_W));
   assign req_boff = CNT_W'(addr_field(bus.dmemaddr, 2, BOFF_W));
   assign req      = bus.dmemREN | bus.dmemWEN;
   assign cnt_last = (cnt_q == CNT_W'(BLK_WORDS - 1));
   assign scan_way  = WAY_W'(32'(scan_q) % WAYS);
   assign scan_set  = IDX_W'(32'(scan_q) / WAYS);
   assign scan_last = (scan_q == SCAN_W'(SETS * WAYS - 1));

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (meta_q[req_idx][w].valid && meta_q[req_idx][w].tag == req_tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      // Descending walk leaves the lowest-numbered invalid way.
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (!meta_q[req_idx][w].valid) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
   end

   assign victim = inv_found ? inv_way : plru_victim;

   dcache_plru #(
      .WAYS(WAYS),
      .SETS(SETS)
   ) u_plru (
      .clk_i       (CLK),
      .rst_i       (RST),
      .idx_i       (req_idx),
      .upd_i       (plru_upd),
      .access_way_i(hit_way),
      .victim_o    (plru_victim)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      scan_d       = scan_q;
      victim_d     = victim_q;
      bus.dhit     = 1'b0;
      bus.dmemload = '0;
      bus.dREN     = 1'b0;
      bus.dWEN     = 1'b0;
      bus.daddr    = '0;
      bus.dstore   = '0;
      bus.flushed  = 1'b0;
      plru_upd     = 1'b0;
      wr_hit       = 1'b0;
      fill_we      = 1'b0;
      fill_done    = 1'b0;
      wb_clean     = 1'b0;
      unique case (state_q)
         StCompare: begin
            if (req && hit) begin
               bus.dhit = 1'b1;
               plru_upd = 1'b1;
               wr_hit   = bus.dmemWEN;
               if (bus.dmemREN) bus.dmemload = data_q[req_idx][hit_way][req_boff];
            end else if (req) begin
               victim_d = victim;
               cnt_d    = '0;
               state_d  = (meta_q[req_idx][victim].valid && meta_q[req_idx][victim].dirty)
                          ? StWb : StFill;
            end
            if (bus.halt && !(req && !hit)) begin
               state_d = StFlushScan;
               scan_d  = '0;
            end
         end
         StWb: begin
            bus.dWEN   = 1'b1;
            bus.daddr  = addr_join(32'(meta_q[req_idx][victim_q].tag), 32'(req_idx), 32'(cnt_q),
                                   BOFF_W, IDX_W);
            bus.dstore = data_q[req_idx][victim_q][cnt_q];
            if (bus.ramstate == RamAccess) begin
               cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
               if (cnt_last) state_d = StFill;
            end
         end
         StFill: begin
            bus.dREN  = 1'b1;
            bus.daddr = addr_join(32'(req_tag), 32'(req_idx), 32'(cnt_q), BOFF_W, IDX_W);
            if (bus.ramstate == RamAccess) begin
               fill_we   = 1'b1;
               fill_done = cnt_last;
               cnt_d     = cnt_last ? '0 : cnt_q + 1'b1;
               if (cnt_last) state_d = StCompare;
            end
         end
         StFlushScan: begin
            if (meta_q[scan_set][scan_way].dirty) begin
               cnt_d   = '0;
               state_d = StFlushWb;
            end else if (scan_last) begin
               state_d = StDone;
            end else begin
               scan_d = scan_q + 1'b1;
            end
         end
         StFlushWb: begin
            bus.dWEN   = 1'b1;
            bus.daddr  = addr_join(32'(meta_q[scan_set][scan_way].tag), 32'(scan_set),
                                   32'(cnt_q), BOFF_W, IDX_W);
            bus.dstore = data_q[scan_set][scan_way][cnt_q];
            if (bus.ramstate == RamAccess) begin
               wb_clean = cnt_last;
               cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;
               if (cnt_last) state_d = StFlushScan;
            end
         end
         StDone: bus.flushed = 1'b1;
         default: state_d = StCompare;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= StCompare;
         cnt_q    <= '0;
         scan_q   <= '0;
         victim_q <= '0;
         for (int s = 0; s < int'(SETS); s++) begin
            for (int w = 0; w < int'(WAYS); w++) meta_q[s][w] <= '0;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         scan_q   <= scan_d;
         victim_q <= victim_d;
         if (wr_hit) meta_q[req_idx][hit_way].dirty <= 1'b1;
         if (fill_done) meta_q[req_idx][victim_q] <= {1'b1, 1'b0, req_tag};
         if (wb_clean) meta_q[scan_set][scan_way].dirty <= 1'b0;
      end
   end

   // Data words carry no reset; valid bits gate their use.
   always_ff @(posedge CLK) begin
      if (wr_hit) data_q[req_idx][hit_way][req_boff] <= bus.dmemstore;
      if (fill_we) data_q[req_idx][victim_q][cnt_q] <= bus.dload;
   end

`ifdef DCACHE_HITCNT_EN
   logic        retry_q, miss_ev;
   logic [31:0] hit_cnt_q, miss_cnt_q;

   assign miss_ev = (state_q == StCompare) && req && !hit;

   // The hit that follows a fill is the retried request, not a new one.
   always_ff @(posedge CLK) begin
      if (RST) begin
         retry_q    <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         retry_q <= fill_done;
         if (bus.dhit && !retry_q && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
         if (miss_ev && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway: cold fill, write hit, dirty eviction, BUSY stall,
// flush and mid-writeback reset, against a pattern memory (word = addr ^ 0x5A5A0000).
module tb_dcache_nway;
   import dcache_nway_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   int   n_err = 0;
   int   n_chk = 0;

   logic        log_we   [64];
   logic [31:0] log_addr [64];
   logic [31:0] log_data [64];
   int          n_log    = 0;
   int          both_cnt = 0;

   dcache_nway_if bus ();

`ifdef DCACHE_HITCNT_EN
   logic [31:0] hit_count, miss_count;
`endif

   dcache_nway #(
      .WAYS     (2),
      .SETS     (8),
      .BLK_WORDS(2)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
`ifdef DCACHE_HITCNT_EN
      ,
      .hit_count (hit_count),
      .miss_count(miss_count)
`endif
   );

   always #5 clk = ~clk;

   assign bus.ramstate = (bus.dREN || bus.dWEN) ? (busy ? RamBusy : RamAccess) : RamFree;
   assign bus.dload    = bus.daddr ^ 32'h5A5A_0000;

   always @(posedge clk) begin
      if ((bus.dREN || bus.dWEN) && bus.ramstate == RamAccess && n_log < 64) begin
         log_we[n_log]   <= bus.dWEN;
         log_addr[n_log] <= bus.daddr;
         log_data[n_log] <= bus.dWEN ? bus.dstore : bus.dload;
         n_log           <= n_log + 1;
      end
   end

   always @(negedge clk) if (bus.dREN && bus.dWEN) both_cnt <= both_cnt + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_log(input string tag, input int i, input logic we,
                            input logic [31:0] a, input logic [31:0] d);
      check({tag, "_we"}, 32'(log_we[i]), 32'(we));
      check({tag, "_addr"}, log_addr[i], a);
      check({tag, "_data"}, log_data[i], d);
   endtask

   // Entered and left just after a rising edge; counts falling edges up to the hit.
   task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                         output int cyc, output logic [31:0] ld);
      bus.dmemaddr  = a;
      bus.dmemstore = d;
      bus.dmemREN   = !we;
      bus.dmemWEN   = we;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.dhit && cyc < 50);
      ld = bus.dmemload;
      @(posedge clk);
      #1;
      bus.dmemREN = 1'b0;
      bus.dmemWEN = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc;
      int          base;
      logic [31:0] ld;

      rst           = 1'b1;
      busy          = 1'b0;
      bus.dmemREN   = 1'b0;
      bus.dmemWEN   = 1'b0;
      bus.dmemaddr  = '0;
      bus.dmemstore = '0;
      bus.halt      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      @(negedge clk);
      check("rst_dhit", 32'(bus.dhit), 0);
      check("rst_dren", 32'(bus.dREN), 0);
      check("rst_dwen", 32'(bus.dWEN), 0);
      check("rst_flushed", 32'(bus.flushed), 0);
      check("rst_daddr", bus.daddr, 0);
      check("rst_dstore", bus.dstore, 0);
      check("rst_dmemload", bus.dmemload, 0);
      @(posedge clk);
      #1;

      base = n_log;
      do_req(1'b0, 32'h40, 32'h0, cyc, ld);
      check("cold_cycles", 32'(cyc), 4);
      check("cold_data", ld, 32'h5A5A_0040);
      check("cold_nlog", 32'(n_log - base), 2);
      check_log("cold_t0", base, 1'b0, 32'h40, 32'h5A5A_0040);
      check_log("cold_t1", base + 1, 1'b0, 32'h44, 32'h5A5A_0044);

      base = n_log;
      do_req(1'b1, 32'h40, 32'hDEAD_BEEF, cyc, ld);
      check("whit_cycles", 32'(cyc), 1);
      do_req(1'b0, 32'h40, 32'h0, cyc, ld);
      check("rhit_cycles", 32'(cyc), 1);
      check("rhit_data", ld, 32'hDEAD_BEEF);
      check("hit_nlog", 32'(n_log - base), 0);

      do_req(1'b0, 32'h240, 32'h0, cyc, ld);
      check("fill240_cycles", 32'(cyc), 4);
      check("fill240_data", ld, 32'h5A5A_0240);
      base = n_log;
      do_req(1'b0, 32'h440, 32'h0, cyc, ld);
      check("evict_cycles", 32'(cyc), 6);
      check("evict_data", ld, 32'h5A5A_0440);
      check("evict_nlog", 32'(n_log - base), 4);
      check_log("evict_t0", base, 1'b1, 32'h40, 32'hDEAD_BEEF);
      check_log("evict_t1", base + 1, 1'b1, 32'h44, 32'h5A5A_0044);
      check_log("evict_t2", base + 2, 1'b0, 32'h440, 32'h5A5A_0440);
      check_log("evict_t3", base + 3, 1'b0, 32'h444, 32'h5A5A_0444);

      base         = n_log;
      busy         = 1'b1;
      bus.dmemaddr = 32'h88;
      bus.dmemREN  = 1'b1;
      @(negedge clk);
      check("busy_miss_dhit", 32'(bus.dhit), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("busy_dren%0d", i), 32'(bus.dREN), 1);
         check($sformatf("busy_daddr%0d", i), bus.daddr, 32'h88);
      end
      busy = 1'b0;
      @(negedge clk);
      check("busy_word1_addr", bus.daddr, 32'h8C);
      @(negedge clk);
      check("busy_hit", 32'(bus.dhit), 1);
      check("busy_data", bus.dmemload, 32'h5A5A_0088);
      @(posedge clk);
      #1;
      bus.dmemREN = 1'b0;
      check("busy_nlog", 32'(n_log - base), 2);
      check_log("busy_t0", base, 1'b0, 32'h88, 32'h5A5A_0088);
      check_log("busy_t1", base + 1, 1'b0, 32'h8C, 32'h5A5A_008C);

      do_req(1'b1, 32'h88, 32'h1111_1111, cyc, ld);
      check("dirty88_cycles", 32'(cyc), 1);
      do_req(1'b1, 32'h244, 32'h2222_2222, cyc, ld);
      check("dirty244_cycles", 32'(cyc), 1);
      do_req(1'b1, 32'h444, 32'h3333_3333, cyc, ld);
      check("dirty444_cycles", 32'(cyc), 1);

      base     = n_log;
      bus.halt = 1'b1;
      cyc      = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.flushed && cyc < 200);
      check("flush_done", 32'(bus.flushed), 1);
      check("flush_nlog", 32'(n_log - base), 6);
      check_log("flush_t0", base, 1'b1, 32'h440, 32'h5A5A_0440);
      check_log("flush_t1", base + 1, 1'b1, 32'h444, 32'h3333_3333);
      check_log("flush_t2", base + 2, 1'b1, 32'h240, 32'h5A5A_0240);
      check_log("flush_t3", base + 3, 1'b1, 32'h244, 32'h2222_2222);
      check_log("flush_t4", base + 4, 1'b1, 32'h88, 32'h1111_1111);
      check_log("flush_t5", base + 5, 1'b1, 32'h8C, 32'h5A5A_008C);
      @(posedge clk);
      #1;
      bus.dmemaddr = 32'h40;
      bus.dmemREN  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("done_flushed%0d", i), 32'(bus.flushed), 1);
         check($sformatf("done_dhit%0d", i), 32'(bus.dhit), 0);
         check($sformatf("done_dren%0d", i), 32'(bus.dREN), 0);
      end
      check("done_nlog", 32'(n_log - base), 6);
      @(posedge clk);
      #1;
      bus.dmemREN = 1'b0;
      bus.halt    = 1'b0;
      rst         = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;

      do_req(1'b0, 32'h40, 32'h0, cyc, ld);
      check("r2_cold_cycles", 32'(cyc), 4);
      do_req(1'b1, 32'h40, 32'hCAFE_F00D, cyc, ld);
      do_req(1'b0, 32'h240, 32'h0, cyc, ld);
      bus.dmemaddr = 32'h440;
      bus.dmemREN  = 1'b1;
      cyc          = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.dWEN && cyc < 10);
      check("wb_seen", 32'(bus.dWEN), 1);
      check("wb_addr", bus.daddr, 32'h40);
      rst         = 1'b1;
      bus.dmemREN = 1'b0;
      @(negedge clk);
      check("wbrst_dwen", 32'(bus.dWEN), 0);
      check("wbrst_dren", 32'(bus.dREN), 0);
      check("wbrst_daddr", bus.daddr, 0);
      check("wbrst_dstore", bus.dstore, 0);
      check("wbrst_dhit", 32'(bus.dhit), 0);
      check("wbrst_flushed", 32'(bus.flushed), 0);
      @(posedge clk);
      #1;
      rst  = 1'b0;
      base = n_log;
      do_req(1'b0, 32'h40, 32'h0, cyc, ld);
      check("postrst_cycles", 32'(cyc), 4);
      check("postrst_nlog", 32'(n_log - base), 2);
      check_log("postrst_t0", base, 1'b0, 32'h40, 32'h5A5A_0040);

      check("never_both_strobes", 32'(both_cnt), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dcache_nway.md
# dcache_nway

Parametrised N-way set-associative write-back data cache sitting between the CPU datapath's dmem port and the memory controller's word-wide RAM port. Generalises the fixed 2-way/8-set/2-word dcache to configurable ways, sets and block size, with tree pseudo-LRU replacement, multi-word writeback/fill bursts and a flush sequence that drains all dirty lines before the CPU halts. Single outstanding miss; datapath stalls on `dhit` low.

## Interface
- `WAYS`, 2: associativity; power of two, 1..8
- `SETS`, 8: sets; power of two, 2..256
- `BLK_WORDS`, 2: words per block; power of two, 1..8
- `CLK` in 1: clock, all state on rising edge
- `RST` in 1: synchronous, active-high reset
- `dmemREN` in 1: datapath read request
- `dmemWEN` in 1: datapath write request; never asserted together with `dmemREN`
- `dmemaddr` in 32: byte address, word aligned
- `dmemstore` in 32: write data
- `dmemload` out 32: read data, valid when `dhit`
- `dhit` out 1: request completes this cycle
- `halt` in 1: level; starts flush
- `flushed` out 1: all dirty lines written back; sticky until reset
- `dREN` out 1: memory read strobe
- `dWEN` out 1: memory write strobe
- `daddr` out 32: memory word address
- `dstore` out 32: memory write data
- `dload` in 32: memory read data
- `ramstate` in 2: `ramstate_t`; transfer completes in the cycle it reads `ACCESS`

## Operation
- Address split: byte offset 2 b, block offset log2(BLK_WORDS), index log2(SETS), tag = rest.
- Frame: valid, dirty, tag, BLK_WORDS data words; per-set PLRU state of WAYS-1 bits.
- FSM states: `COMPARE`, `WB`, `FILL`, `FLUSH_SCAN`, `FLUSH_WB`, `DONE`.
- `COMPARE`: on a tag match in a valid way, assert `dhit` combinationally. A read drives `dmemload`. A write updates the word, sets dirty and updates PLRU toward that way. A miss selects a victim: the lowest-numbered invalid way, else the PLRU way. Go to `WB` if the victim is valid and dirty, else go to `FILL`.
- `WB`: issue `dWEN` for victim words 0..BLK_WORDS-1 at the victim's tag/index. Advance the word counter on `ACCESS`, then go to `FILL`.
- `FILL`: issue `dREN` for the requested block words 0..BLK_WORDS-1, writing each into the victim frame on `ACCESS`. After the last word, set valid, clear dirty, write the tag and return to `COMPARE`. The retried request then hits.
- `ERROR`/`BUSY`: the strobe and address are held and the counter does not advance.
- Flush: `halt` seen in `COMPARE` with no miss pending goes to `FLUSH_SCAN`. The scan walks set-major, way-minor, one frame per cycle. Each dirty frame goes to `FLUSH_WB`, which writes back, clears dirty and resumes the scan. After the last frame go to `DONE`, where `flushed`=1, all requests are ignored and `dhit`=0.
- A `halt` raised during a miss is honoured after the miss completes.

## Timing
- Reset values: all valid, dirty and PLRU bits 0; state `COMPARE`; counters 0. Outputs `dhit`, `dREN`, `dWEN`, `flushed` = 0; `daddr`, `dstore`, `dmemload` = 0.
- Hit: 0-cycle latency.
- Clean miss: BLK_WORDS memory transfers plus 1 cycle, then the hit.
- Dirty miss: 2×BLK_WORDS transfers plus 1 cycle.
- `dREN` and `dWEN` are never high together.
- `RST` in any state aborts the burst and returns to reset values on the next edge.

## Configuration
- `DCACHE_HITCNT_EN`: when defined, adds 32-bit saturating `hit_count` and `miss_count` output ports.
  - `hit_count` increments once per completed request that hit on first lookup.
  - `miss_count` increments once per miss; the post-fill hit does not count.
  - Both counters are cleared by `RST`.
- When not defined, the ports and logic are absent.

## Structure
- `caches_pkg` additions:
  - `dcache_frame` generalised to a parameterised block
  - `dcstate_t` enum for the FSM states
  - an address-split function parameterised by width constants
- Sub-module `dcache_plru`: per-set tree PLRU.
  - Inputs: access way and update enable.
  - Output: victim way.
  - With WAYS=1 it is a constant 0.

## Test plan
- Defaults, read 0x40 cold: `dREN` for 0x40 then 0x44, two `ACCESS` responses, then `dhit`=1 with `dmemload`=word 0.
- Write 0xDEADBEEF to 0x40 after fill: `dhit` same cycle; a read of 0x40 returns 0xDEADBEEF with no memory traffic.
- Dirty 0x40 (set 0), then read 0x240 and 0x440 (same set): the second miss evicts 0x40. Expect `dWEN` to 0x40/0x44 with 0xDEADBEEF first, then `dREN` to 0x440/0x444.
- Set `ramstate`=`BUSY` for 3 cycles during `FILL`: address held, counter frozen, data correct.
- Dirty 3 lines, raise `halt`: exactly 6 `dWEN` transfers, then `flushed`=1 and it stays high.
- `RST` mid-`WB`: next cycle all outputs at reset values, and a read of 0x40 misses.
